// File: rtl/packet_parser_pkg.sv
// Shared constants for the packet parser: field bit positions, FSM encodings, defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Also provides the frame checksum helper used by the parser's CHECK state.
package packet_parser_pkg;

    localparam int FIFO_DEPTH_DEF = 4;

    // Field map inside the 64-bit upstream frame
    localparam int ADDR_LSB = 25;
    localparam int ADDR_W   = 7;
    localparam int DATA_LSB = 9;
    localparam int DATA_W   = 16;
    localparam int CHK_LSB  = 37;
    localparam int CHK_W    = 8;
    localparam int CMD_LSB  = 45;
    localparam int CMD_W    = 4;

    // One FIFO entry is {addr, data, cmd}
    localparam int ENTRY_W  = ADDR_W + DATA_W + CMD_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // 8-bit sum wraps naturally, giving the mod-256 checksum
    function automatic logic [7:0] calc_chk(input logic [6:0] addr, input logic [15:0] data);
        return {1'b0, addr} + data[15:8] + data[7:0];
    endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous FIFO holding parsed packet entries for the output port.
// Latency: a push is visible at pop_dat/empty the cycle after the push edge.
// Backpressure: caller must only push when !full or when popping in the same cycle.
//
// Ports: clk, rst (sync active-low), push/push_dat, pop/pop_dat (head, combinational),
//        full, empty. Pointers carry one extra wrap bit to tell full from empty.
module pkt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset; validity is tracked entirely by the pointers.
    // A push into a full FIFO with a coincident pop overwrites the slot being popped.
    always_ff @(posedge clk) begin
        if (rst && push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    assign pop_dat = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/packet_parser.sv
// Captures a frame on pkt_rec, verifies its checksum and queues {addr,data,cmd}.
// Latency: pkt_rec rising in cycle N gives out_valid in cycle N+2 (empty FIFO).
// Backpressure: out_valid/out_ready handshake; a good frame arriving at a full FIFO is dropped.
//
// Ports: clk, rst (sync active-low); pkt_data/pkt_rec from the upstream shift stage;
//        out_valid/out_ready/out_addr/out_data/out_cmd = FIFO head; chk_err pulse;
//        good_cnt/bad_cnt/drop_cnt statistics, present only with PACKET_PARSER_STATS_EN.
module packet_parser
    import packet_parser_pkg::*;
#(
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      pkt_data,
    input  logic             pkt_rec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [6:0]       out_addr,
    output logic [15:0]      out_data,
    output logic [3:0]       out_cmd,
    output logic             chk_err,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt,
    output logic [CNT_W-1:0] drop_cnt
);

    logic [1:0]         state;
    logic [63:0]        cap_q;
    logic [ADDR_W-1:0]  cap_addr;
    logic [DATA_W-1:0]  cap_data;
    logic [CHK_W-1:0]   cap_chk;
    logic [CMD_W-1:0]   cap_cmd;
    logic               chk_ok;
    logic               in_check;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               do_push;
    logic               do_bad;
    logic [ENTRY_W-1:0] head;
    logic               unused_cap_bits;

    assign cap_addr = cap_q[ADDR_LSB +: ADDR_W];
    assign cap_data = cap_q[DATA_LSB +: DATA_W];
    assign cap_chk  = cap_q[CHK_LSB  +: CHK_W];
    assign cap_cmd  = cap_q[CMD_LSB  +: CMD_W];

    // Sync pattern and spare bits carry no meaning here
    assign unused_cap_bits = ^{cap_q[63:49], cap_q[36:32], cap_q[8:0]};

    assign chk_ok   = (cap_chk == calc_chk(cap_addr, cap_data));
    assign in_check = (state == ST_CHECK);
    assign pop      = out_valid && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept
    assign do_push  = in_check && chk_ok && (!fifo_full || pop);
    assign do_bad   = in_check && !chk_ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            cap_q   <= '0;
            chk_err <= 1'b0;
        end else begin
            chk_err <= do_bad;
            case (state)
                ST_IDLE: begin
                    if (pkt_rec) begin
                        cap_q <= pkt_data;
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: state <= ST_HOLD;
                // Wait out the rest of the pkt_rec level so one level means one packet
                ST_HOLD: begin
                    if (!pkt_rec) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    pkt_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (do_push),
        .push_dat ({cap_addr, cap_data, cap_cmd}),
        .pop      (pop),
        .pop_dat  (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_addr  = out_valid ? head[ENTRY_W-1 -: ADDR_W]       : '0;
    assign out_data  = out_valid ? head[CMD_W +: DATA_W]           : '0;
    assign out_cmd   = out_valid ? head[CMD_W-1:0]                 : '0;

`ifdef PACKET_PARSER_STATS_EN
    logic do_drop;
    assign do_drop = in_check && chk_ok && fifo_full && !pop;

    // Saturating counters: hold at all-ones rather than wrap
    always_ff @(posedge clk) begin
        if (!rst) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (do_push && (good_cnt != '1)) begin
                good_cnt <= good_cnt + CNT_W'(1);
            end
            if (do_bad && (bad_cnt != '1)) begin
                bad_cnt <= bad_cnt + CNT_W'(1);
            end
            if (do_drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign good_cnt = '0;
    assign bad_cnt  = '0;
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_packet_parser.sv
// Self-checking bench for packet_parser: directed frames plus randomized traffic.
// Every cycle the DUT outputs are compared against a queue-based packet model.
// Counter expectations follow PACKET_PARSER_STATS_EN (zero when undefined).
module tb_packet_parser;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
`ifdef PACKET_PARSER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [63:0]       pkt_data = '0;
    logic              pkt_rec = 1'b0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [6:0]        out_addr;
    logic [15:0]       out_data;
    logic [3:0]        out_cmd;
    logic              chk_err;
    logic [CNT_W-1:0]  good_cnt;
    logic [CNT_W-1:0]  bad_cnt;
    logic [CNT_W-1:0]  drop_cnt;

    packet_parser #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pkt_data  (pkt_data),
        .pkt_rec   (pkt_rec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .out_cmd   (out_cmd),
        .chk_err   (chk_err),
        .good_cnt  (good_cnt),
        .bad_cnt   (bad_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  addr;
        logic [15:0] data;
        logic [3:0]  cmd;
    } ent_t;

    // Reference model state
    ent_t        q[$];
    int          m_good, m_bad, m_drop;
    bit          m_err;
    bit          pend_vld;
    logic [63:0] pend;
    bit          prev_rec;

    int n_checks = 0;
    int n_errors = 0;
    int rdy_mode = 0;   // 0: ready low, 1: ready high, 2: random, 3: driven by caller

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sum_chk(input logic [6:0] a, input logic [15:0] d);
        int s;
        s = int'(a) + int'(d[15:8]) + int'(d[7:0]);
        return 8'(s % 256);
    endfunction

    function automatic bit frame_ok(input logic [63:0] f);
        return sum_chk(f[31:25], f[24:9]) == f[44:37];
    endfunction

    // Random filler everywhere, then the meaningful fields on top
    function automatic logic [63:0] mk(input logic [6:0] a, input logic [15:0] d,
                                       input logic [3:0] c, input logic [7:0] k);
        logic [63:0] f;
        f = {$urandom, $urandom};
        f[31:25] = a;
        f[24:9]  = d;
        f[44:37] = k;
        f[48:45] = c;
        return f;
    endfunction

    function automatic logic [63:0] rand_frame(input bit good);
        logic [6:0]  a;
        logic [15:0] d;
        logic [3:0]  c;
        logic [7:0]  k;
        a = 7'($urandom);
        d = 16'($urandom);
        c = 4'($urandom);
        k = sum_chk(a, d);
        if (!good) k = k ^ 8'($urandom_range(1, 255));
        return mk(a, d, c, k);
    endfunction

    function automatic int sat(input int c);
        return (c < (1 << CNT_W) - 1) ? c + 1 : c;
    endfunction

    function automatic logic [63:0] exp_cnt(input int c);
        return STATS ? 64'(c) : 64'd0;
    endfunction

    // One clock: advance the model with the inputs the DUT will see, then compare outputs
    task automatic step();
        bit   pop;
        bit   push;
        bit   err_n;
        ent_t e;
        pop = 1'b0; push = 1'b0; err_n = 1'b0;
        if (!rst) begin
            q.delete();
            m_good = 0; m_bad = 0; m_drop = 0;
            m_err = 1'b0; pend_vld = 1'b0; prev_rec = 1'b0;
        end else begin
            pop = out_ready && (q.size() != 0);
            if (pend_vld) begin
                if (frame_ok(pend)) begin
                    if (q.size() < DEPTH || pop) push = 1'b1;
                    else m_drop = sat(m_drop);
                end else begin
                    m_bad = sat(m_bad);
                    err_n = 1'b1;
                end
            end
            if (pop) void'(q.pop_front());
            if (push) begin
                e.addr = pend[31:25];
                e.data = pend[24:9];
                e.cmd  = pend[48:45];
                q.push_back(e);
                m_good = sat(m_good);
            end
            // A frame is taken on the first high cycle of each pkt_rec level
            pend_vld = pkt_rec && !prev_rec;
            pend     = pkt_data;
            prev_rec = pkt_rec;
            m_err    = err_n;
        end
        @(posedge clk);
        @(negedge clk);
        check("out_valid", out_valid, (q.size() != 0));
        check("head", {out_addr, out_data, out_cmd}, (q.size() != 0) ? q[0] : ent_t'(0));
        check("chk_err", chk_err, m_err);
        check("good_cnt", good_cnt, exp_cnt(m_good));
        check("bad_cnt", bad_cnt, exp_cnt(m_bad));
        check("drop_cnt", drop_cnt, exp_cnt(m_drop));
    endtask

    task automatic cyc(input logic rec, input logic [63:0] d);
        pkt_rec  = rec;
        pkt_data = d;
        if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
        else if (rdy_mode != 3) out_ready = (rdy_mode == 1);
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, {$urandom, $urandom});
    endtask

    task automatic send(input logic [63:0] f, input int hi, input int lo);
        repeat (hi) cyc(1'b1, f);
        idle(lo);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
    endtask

    logic [63:0] frames [5];
    logic [63:0] f0;

    initial begin
        // Reset state (checked inside step while rst is low)
        rdy_mode = 1;
        do_reset();

        // Known good frame: latency N+2 and fields
        f0 = mk(7'h12, 16'hABCD, 4'h5, 8'h8A);
        cyc(1'b1, f0);
        idle(1);
        check("lat_valid", out_valid, 1'b1);
        check("lat_addr", out_addr, 7'h12);
        check("lat_data", out_data, 16'hABCD);
        check("lat_cmd", out_cmd, 4'h5);
        idle(2);
        check("good_one", good_cnt, STATS ? 64'd1 : 64'd0);

        // Same frame with a wrong checksum
        do_reset();
        cyc(1'b1, mk(7'h12, 16'hABCD, 4'h5, 8'h8B));
        idle(1);
        check("bad_pulse", chk_err, 1'b1);
        check("bad_noval", out_valid, 1'b0);
        idle(1);
        check("bad_pulse_end", chk_err, 1'b0);
        check("bad_one", bad_cnt, STATS ? 64'd1 : 64'd0);

        // Long pkt_rec level yields a single packet
        do_reset();
        send(rand_frame(1'b1), 10, 3);
        check("long_level", good_cnt, STATS ? 64'd1 : 64'd0);

        // Five frames into a stalled 4-deep FIFO, then drain in order
        do_reset();
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) begin
            frames[i] = rand_frame(1'b1);
            send(frames[i], 1, 3);
        end
        check("overflow_drop", drop_cnt, STATS ? 64'd1 : 64'd0);
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) begin
            check("drain_order", {out_addr, out_data, out_cmd},
                  {frames[i][31:25], frames[i][24:9], frames[i][48:45]});
            idle(1);
        end
        check("drain_empty", out_valid, 1'b0);

        // Full FIFO, push coincident with pop
        do_reset();
        rdy_mode = 0;
        for (int i = 0; i < 4; i++) begin
            frames[i] = rand_frame(1'b1);
            send(frames[i], 1, 3);
        end
        frames[4] = rand_frame(1'b1);
        rdy_mode = 3;
        out_ready = 1'b0;
        cyc(1'b1, frames[4]);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        idle(2);
        check("coinc_nodrop", drop_cnt, 64'd0);
        check("coinc_head", {out_addr, out_data, out_cmd},
              {frames[1][31:25], frames[1][24:9], frames[1][48:45]});
        rdy_mode = 1;
        idle(6);

        // Reset while in CHECK aborts the packet
        do_reset();
        cyc(1'b1, rand_frame(1'b1));
        rst = 1'b0;
        cyc(1'b0, {$urandom, $urandom});
        rst = 1'b1;
        idle(3);
        check("abort_noval", out_valid, 1'b0);
        check("abort_good", good_cnt, 64'd0);

        // pkt_rec still high across reset release is captured afterwards
        f0 = rand_frame(1'b1);
        rst = 1'b0;
        cyc(1'b1, f0);
        rst = 1'b1;
        send(f0, 3, 3);
        check("post_rst_cap", good_cnt, STATS ? 64'd1 : 64'd0);

        // Randomized traffic with random backpressure
        do_reset();
        rdy_mode = 2;
        for (int i = 0; i < 200; i++) begin
            send(rand_frame($urandom_range(0, 9) < 7), $urandom_range(1, 4), $urandom_range(2, 4));
        end
        rdy_mode = 1;
        idle(8);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
